// File: rtl/vit_sched_e213.sv
// Viterbi decoder sequencer: per-symbol LOAD/ACS/WRITE strobes, survivor
// write pointer, and block traceback scheduling over a 3-block circular
// survivor memory.
module vit_sched_e213 #(
  parameter int BLOCK = 8,
  parameter int PTR_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_valid,
  output logic             le,
  output logic             ae,
  output logic             we,
  output logic [PTR_W-1:0] write_ptr,
  output logic             be,
  output logic             te,
  output logic [PTR_W-1:0] trace_ptr,
  output logic             oe,
  output logic [CNT_W-1:0] block_count,
  output logic             busy,
  output logic             overrun
);

  localparam int DEPTH = 3 * BLOCK;
  localparam int BC_W  = $clog2(BLOCK);
  localparam int RC_W  = $clog2(2 * BLOCK);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [BC_W-1:0]  LAST_BLK  = BC_W'(BLOCK - 1);
  localparam logic [RC_W-1:0]  LAST_RUN  = RC_W'(2 * BLOCK - 1);
  localparam logic [RC_W-1:0]  MERGE_LEN = RC_W'(BLOCK);

  typedef enum logic [1:0] {PH_IDLE, PH_LOAD, PH_ACS, PH_WRITE} phase_t;
  typedef enum logic [1:0] {TB_IDLE, TB_LOAD, TB_RUN} tb_t;

  phase_t          ph_state, ph_next;
  tb_t             tb_state, tb_next;
  logic [BC_W-1:0] blk_cnt;
  logic [RC_W-1:0] run_cnt;
  logic            first_done;
  logic            block_end;
  logic            tb_start;

  assign block_end = (ph_state == PH_WRITE) && (blk_cnt == LAST_BLK);
  // Traceback starts from the second block end onwards; first_done marks
  // that one block is already in the survivor memory.
  assign tb_start  = block_end && first_done && (tb_state == TB_IDLE);

  // Phase and traceback state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_state <= PH_IDLE;
      tb_state <= TB_IDLE;
    end else begin
      ph_state <= ph_next;
      tb_state <= tb_next;
    end
  end

  // Phase next-state and Moore strobes
  always_comb begin
    ph_next = ph_state;
    le = 1'b0;
    ae = 1'b0;
    we = 1'b0;
    case (ph_state)
      PH_IDLE:  if (rx_valid) ph_next = PH_LOAD;
      PH_LOAD:  begin le = 1'b1; ph_next = PH_ACS; end
      PH_ACS:   begin ae = 1'b1; ph_next = PH_WRITE; end
      PH_WRITE: begin
        we = 1'b1;
        ph_next = rx_valid ? PH_LOAD : PH_IDLE;
      end
      default:  ph_next = PH_IDLE;
    endcase
  end

  // Write-side pointer, in-block counter, block counter and overrun flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_ptr   <= '0;
      blk_cnt     <= '0;
      block_count <= '0;
      first_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (we) begin
        write_ptr <= (write_ptr == LAST_PTR) ? '0 : write_ptr + 1'b1;
        blk_cnt   <= block_end ? '0 : blk_cnt + 1'b1;
        if (block_end) begin
          block_count <= block_count + 1'b1;
          first_done  <= 1'b1;
        end
      end
      if (rx_valid && (le || ae))
        overrun <= 1'b1;
    end
  end

  // Traceback next-state and strobes
  always_comb begin
    tb_next = tb_state;
    be = 1'b0;
    te = 1'b0;
    oe = 1'b0;
    case (tb_state)
      TB_IDLE: if (tb_start) tb_next = TB_LOAD;
      TB_LOAD: begin be = 1'b1; tb_next = TB_RUN; end
      TB_RUN:  begin
        te = 1'b1;
        oe = (run_cnt >= MERGE_LEN);
        if (run_cnt == LAST_RUN) tb_next = TB_IDLE;
      end
      default: tb_next = TB_IDLE;
    endcase
  end

  assign busy = be | te;

  // Traceback read pointer and run counter; the pointer is not stepped on
  // the final run cycle so it holds the last address read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_ptr <= '0;
      run_cnt   <= '0;
    end else if (tb_start) begin
      trace_ptr <= write_ptr;
    end else if (be) begin
      run_cnt <= '0;
    end else if (te) begin
      run_cnt <= run_cnt + 1'b1;
      if (run_cnt != LAST_RUN)
        trace_ptr <= (trace_ptr == '0) ? LAST_PTR : trace_ptr - 1'b1;
    end
  end

endmodule

// File: doc/vit_sched_e213.md
# vit_sched_e213

Sequencer for the efficient (2,1,3) Viterbi decoder. It drives the per-symbol load/ACS/write phase strobes (`le`, `ae`, `we`) and owns the survivor-memory write pointer. It also schedules block traceback (`be`, `te`, `oe`, `trace_ptr`) over a 3-block circular survivor memory. It sits between the symbol source and the ACS/survivor/traceback datapath, replacing the ad-hoc control inside the decoder top level.

## Interface
- `BLOCK`, default 8: traceback/output block length L, in symbols; must be ≥ 2.
- `PTR_W`, default 5: pointer width; 2^PTR_W ≥ 3*BLOCK.
- `CNT_W`, default 8: `block_count` width.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rx_valid`  in  1: new received symbol present on `Rx` this cycle.
- `le`  out  1: load branch metrics (LOAD phase).
- `ae`  out  1: ACS enable (ACS phase).
- `we`  out  1: survivor write enable (WRITE phase).
- `write_ptr`  out  PTR_W: survivor write address.
- `be`  out  1: block-end pulse; datapath loads `tb_reg` from `min_state`.
- `te`  out  1: traceback step enable.
- `trace_ptr`  out  PTR_W: survivor read address.
- `oe`  out  1: `Dx` valid (decode half of traceback).
- `block_count`  out  CNT_W: completed blocks, wraps.
- `busy`  out  1: traceback in progress (`be` or `te`).
- `overrun`  out  1: sticky; symbol arrived mid-phase.

## Operation
- Reset (`reset`=0, asynchronous): all outputs 0, both FSMs idle, primed flag and in-block counter cleared. Reset asserted mid-traceback aborts it immediately.
- Phase FSM: IDLE → LOAD → ACS → WRITE.
  - IDLE→LOAD when `rx_valid`.
  - LOAD→ACS and ACS→WRITE unconditionally.
  - WRITE→LOAD if `rx_valid`, else IDLE.
  - `le`=LOAD, `ae`=ACS, `we`=WRITE; all are Moore outputs, exactly one-hot or all zero.
- `rx_valid` in LOAD or ACS: symbol dropped, `overrun`←1 (cleared only by reset). The phase sequence is unaffected.
- At the end of each WRITE cycle, `write_ptr` increments modulo 3*BLOCK (3*BLOCK-1 → 0), and the in-block counter increments modulo BLOCK.
- Block end = the WRITE in which the in-block counter is BLOCK-1. On that edge, `block_count` increments (wraps at 2^CNT_W).
- Primed = at least 2 blocks completed since reset. Set on the 2nd block end, and that block end itself triggers traceback.
- Traceback FSM: TB_IDLE → TB_LOAD → TB_RUN → TB_IDLE.
  - On a primed block end with write address P: next cycle is TB_LOAD with `be`=1 and `trace_ptr`=P.
  - Then 2*BLOCK TB_RUN cycles with `te`=1. `trace_ptr` steps P, P-1, …, P-2*BLOCK+1, decrementing modulo 3*BLOCK (0 → 3*BLOCK-1).
  - The first BLOCK TB_RUN cycles are merge (`oe`=0). The last BLOCK cycles have `oe`=1.
- After TB_RUN, `trace_ptr` holds its last value; `te`/`oe` return to 0.
- Collision-free by construction: the next block's writes hit P+1…P+BLOCK, outside the traced range. The next block end is ≥3*BLOCK cycles after the previous one, and traceback lasts 2*BLOCK+1 cycles.
- A block end while `busy` is structurally impossible; the bench flags it by assertion.

## Timing
- `rx_valid` at cycle t from IDLE: `le` at t+1, `ae` at t+2, `we` at t+3; `write_ptr` advances after t+3.
- Back-to-back symbols: one per 3 cycles, no bubbles.
- Block-end WRITE at cycle w (address P):
  - `be` at w+1.
  - `te` during w+2 … w+2*BLOCK+1.
  - `oe` during w+BLOCK+2 … w+2*BLOCK+1.
  - `busy` during w+1 … w+2*BLOCK+1.
- Write-side and traceback activity proceed concurrently and independently.

## Test plan
- Reset: hold `reset`=0 with `rx_valid`=1, then release → all outputs 0 until first `rx_valid`; first `le` one cycle after `rx_valid` is sampled.
- Stream, BLOCK=4, `rx_valid` every 3rd cycle for 24 symbols:
  - `le`/`ae`/`we` repeat with period 3.
  - `write_ptr` runs 0…11,0…11.
  - `block_count` ends at 6.
  - First `be` follows the 8th WRITE (P=7).
- Traceback, BLOCK=4, P=7:
  - `trace_ptr` = 7,6,5,4,3,2,1,0 over 8 `te` cycles.
  - `oe` asserted only for ptr 3..0.
  - Next traceback (P=11) reads 11…4.
  - Traceback with P=3 reads 3,2,1,0,11,10,9,8 (wrap).
- Gaps: random idle gaps between symbols → `write_ptr`, `be` and traceback addresses identical to the gap-free run, only delayed.
- Overrun: `rx_valid` asserted in the LOAD cycle → `overrun`=1 and stays 1; `write_ptr` advances once only.
- Mid-traceback reset: assert `reset` during 3rd `te` cycle → `te`, `oe`, `busy` fall asynchronously. After release, no `be` until 2 new blocks complete.
